iq_reclaim_arbiter: RTL and testbench



---
 rtl/iq_reclaim_arbiter.sv | 141 ++++++++++++++
 tb/tb_iq_reclaim_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/iq_reclaim_arbiter.sv
// Issue-queue reclaim engine: granted entries wait in a pending vector and are
// handed back to the free list through per-block valid/ready offer ports.
module iq_reclaim_arbiter #(
  parameter int NUM_ENTRIES = 32,
  parameter int ENTRY_LOG   = 5,
  parameter int GRANT_PORTS = 4,
  parameter int FREE_PORTS  = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [GRANT_PORTS-1:0]           grantValid_i,
  input  logic [GRANT_PORTS*ENTRY_LOG-1:0] grantId_i,
  input  logic                             flush_i,
  input  logic [FREE_PORTS-1:0]            freeReady_i,
  output logic [FREE_PORTS-1:0]            freeValid_o,
  output logic [FREE_PORTS*ENTRY_LOG-1:0]  freeId_o,
  output logic [ENTRY_LOG:0]               pendingCount_o,
  output logic                             dupGrant_o
);

  localparam int EPB  = NUM_ENTRIES / FREE_PORTS;
  localparam int SPAN = 1 << ENTRY_LOG;

  logic [NUM_ENTRIES-1:0] pending;
  logic [ENTRY_LOG-1:0]   rrPtr [FREE_PORTS];

  // Id-indexed views padded to the full id space so any id can index them.
  logic [SPAN-1:0]        pendWide;
  logic [SPAN-1:0]        offeredWide;
  logic [SPAN-1:0]        setWide;
  logic [SPAN-1:0]        clearWide;
  logic [FREE_PORTS-1:0]  accept;
  logic [FREE_PORTS-1:0]  load;
  logic [FREE_PORTS-1:0]  validNext;
  logic [ENTRY_LOG-1:0]   selId  [FREE_PORTS];
  logic [ENTRY_LOG-1:0]   rrNext [FREE_PORTS];
  logic [NUM_ENTRIES-1:0] pendingNext;
  logic [ENTRY_LOG:0]     countNext;
  logic                   dupNow;
  logic                   dupLane;
  logic [ENTRY_LOG-1:0]   gid;
  int                     lo;
  int                     blkSize;
  int                     start;
  int                     k;
  int                     cnt;

  always_comb begin
    pendWide    = SPAN'(pending);
    offeredWide = '0;
    clearWide   = '0;
    setWide     = '0;
    accept      = freeValid_o & freeReady_i;
    load        = '0;
    validNext   = '0;
    dupNow      = 1'b0;
    dupLane     = 1'b0;
    gid         = '0;
    lo          = 0;
    blkSize     = 0;
    start       = 0;
    k           = 0;
    cnt         = 0;

    for (int p = 0; p < FREE_PORTS; p++) begin
      if (freeValid_o[p]) offeredWide[freeId_o[p*ENTRY_LOG +: ENTRY_LOG]] = 1'b1;
    end

    // Per-block search; the last block absorbs the remainder entries.
    for (int p = 0; p < FREE_PORTS; p++) begin
      lo        = p * EPB;
      blkSize   = (p == FREE_PORTS - 1) ? (NUM_ENTRIES - lo) : EPB;
      start     = (ROUND_ROBIN != 0) ? int'(rrPtr[p]) : 0;
      selId[p]  = '0;
      rrNext[p] = rrPtr[p];
      if (!freeValid_o[p] || accept[p]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          k = start + i;
          if (k >= blkSize) k = k - blkSize;
          if (i < blkSize && !load[p] && pendWide[ENTRY_LOG'(lo + k)]) begin
            load[p]   = 1'b1;
            selId[p]  = ENTRY_LOG'(lo + k);
            rrNext[p] = (k + 1 == blkSize) ? '0 : ENTRY_LOG'(k + 1);
          end
        end
      end
      if (load[p]) clearWide[selId[p]] = 1'b1;
      validNext[p] = load[p] | (freeValid_o[p] & ~accept[p]);
    end

    // Earlier lanes win a same-cycle collision; losers only raise the flag.
    for (int j = 0; j < GRANT_PORTS; j++) begin
      gid     = grantId_i[j*ENTRY_LOG +: ENTRY_LOG];
      dupLane = 1'b0;
      if (grantValid_i[j]) begin
        if (int'(gid) >= NUM_ENTRIES) dupLane = 1'b1;
        if (pendWide[gid] || offeredWide[gid]) dupLane = 1'b1;
        for (int m = 0; m < GRANT_PORTS; m++) begin
          if (m < j && grantValid_i[m] && grantId_i[m*ENTRY_LOG +: ENTRY_LOG] == gid)
            dupLane = 1'b1;
        end
        if (dupLane) dupNow = 1'b1;
        else         setWide[gid] = 1'b1;
      end
    end

    pendingNext = (pending & ~clearWide[NUM_ENTRIES-1:0]) | setWide[NUM_ENTRIES-1:0];

    for (int e = 0; e < NUM_ENTRIES; e++) cnt = cnt + int'(pendingNext[e]);
    for (int p = 0; p < FREE_PORTS; p++)  cnt = cnt + int'(validNext[p]);
    countNext = (ENTRY_LOG+1)'(cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= '0;
      freeValid_o    <= '0;
      freeId_o       <= '0;
      pendingCount_o <= '0;
      dupGrant_o     <= 1'b0;
      for (int p = 0; p < FREE_PORTS; p++) rrPtr[p] <= '0;
    end else if (flush_i) begin
      pending        <= '0;
      freeValid_o    <= '0;
      pendingCount_o <= '0;
    end else begin
      pending        <= pendingNext;
      freeValid_o    <= validNext;
      pendingCount_o <= countNext;
      dupGrant_o     <= dupGrant_o | dupNow;
      for (int p = 0; p < FREE_PORTS; p++) begin
        if (load[p]) begin
          freeId_o[p*ENTRY_LOG +: ENTRY_LOG] <= selId[p];
          rrPtr[p]                           <= rrNext[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_reclaim_arbiter.sv
// Random grant/ready/flush traffic on a round-robin 32-entry instance and a
// lowest-first 30-entry instance, both checked against a set-based model.
module tb_iq_reclaim_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  gValid;
  logic [19:0] gIdFlat;
  logic        flushIn;
  logic [3:0]  rdy;

  logic [3:0]  fvA, fvB;
  logic [19:0] fidA, fidB;
  logic [5:0]  cntA, cntB;
  logic        dupA, dupB;

  iq_reclaim_arbiter #(.NUM_ENTRIES(32), .ENTRY_LOG(5), .GRANT_PORTS(4),
                       .FREE_PORTS(4), .ROUND_ROBIN(1)) dutA (
    .clk(clk), .reset(reset), .grantValid_i(gValid), .grantId_i(gIdFlat),
    .flush_i(flushIn), .freeReady_i(rdy), .freeValid_o(fvA), .freeId_o(fidA),
    .pendingCount_o(cntA), .dupGrant_o(dupA));

  iq_reclaim_arbiter #(.NUM_ENTRIES(30), .ENTRY_LOG(5), .GRANT_PORTS(4),
                       .FREE_PORTS(4), .ROUND_ROBIN(0)) dutB (
    .clk(clk), .reset(reset), .grantValid_i(gValid), .grantId_i(gIdFlat),
    .flush_i(flushIn), .freeReady_i(rdy), .freeValid_o(fvB), .freeId_o(fidB),
    .pendingCount_o(cntB), .dupGrant_o(dupB));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Model: entry sets and offer slots, per instance u (0 = A, 1 = B).
  int cfgN  [2] = '{32, 30};
  int cfgRr [2] = '{1, 0};
  bit mPend [2][32];
  bit mOffV [2][4];
  int mOffId[2][4];
  int mRr   [2][4];
  bit mDup  [2];

  function automatic bit isOffered(input int u, input int id);
    for (int p = 0; p < 4; p++) if (mOffV[u][p] && mOffId[u][p] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input int u);
    int n, epb, lo, sz, k, id;
    bit found;
    bit seen[32];
    bit setv[32];
    n   = cfgN[u];
    epb = n / 4;
    if (reset) begin
      for (int e = 0; e < 32; e++) mPend[u][e] = 0;
      for (int p = 0; p < 4; p++) begin mOffV[u][p] = 0; mRr[u][p] = 0; end
      mDup[u] = 0;
      return;
    end
    if (flushIn) begin
      for (int e = 0; e < 32; e++) mPend[u][e] = 0;
      for (int p = 0; p < 4; p++) mOffV[u][p] = 0;
      return;
    end
    for (int e = 0; e < 32; e++) begin seen[e] = 0; setv[e] = 0; end
    for (int j = 0; j < 4; j++) begin
      if (gValid[j]) begin
        id = int'(gIdFlat[j*5 +: 5]);
        if (id >= n || mPend[u][id] || isOffered(u, id) || seen[id]) mDup[u] = 1;
        else setv[id] = 1;
        seen[id] = 1;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (!mOffV[u][p] || rdy[p]) begin
        lo    = p * epb;
        sz    = (p == 3) ? n - lo : epb;
        found = 0;
        k     = 0;
        for (int i = 0; i < sz && !found; i++) begin
          k = ((cfgRr[u] != 0 ? mRr[u][p] : 0) + i) % sz;
          if (mPend[u][lo + k]) found = 1;
        end
        mOffV[u][p] = found;
        if (found) begin
          mOffId[u][p]     = lo + k;
          mPend[u][lo + k] = 0;
          mRr[u][p]        = (k + 1) % sz;
        end
      end
    end
    for (int e = 0; e < 32; e++) if (setv[e]) mPend[u][e] = 1;
  endtask

  task automatic checkOutputs(input int u, input int cyc);
    logic [3:0]  fv;
    logic [19:0] fid;
    logic [5:0]  cnt;
    logic        dup;
    int          expCnt;
    fv  = (u == 0) ? fvA  : fvB;
    fid = (u == 0) ? fidA : fidB;
    cnt = (u == 0) ? cntA : cntB;
    dup = (u == 0) ? dupA : dupB;
    expCnt = 0;
    for (int e = 0; e < 32; e++) expCnt += int'(mPend[u][e]);
    for (int p = 0; p < 4; p++) begin
      expCnt += int'(mOffV[u][p]);
      checkVal($sformatf("u%0d valid%0d c%0d", u, p, cyc), 32'(fv[p]), 32'(mOffV[u][p]));
      if (mOffV[u][p])
        checkVal($sformatf("u%0d id%0d c%0d", u, p, cyc), 32'(fid[p*5 +: 5]), 32'(mOffId[u][p]));
    end
    checkVal($sformatf("u%0d count c%0d", u, cyc), 32'(cnt), 32'(expCnt));
    checkVal($sformatf("u%0d dup c%0d", u, cyc), 32'(dup), 32'(mDup[u]));
  endtask

  initial begin
    int phase;
    reset   = 1'b1;
    gValid  = '0;
    gIdFlat = '0;
    flushIn = 1'b0;
    rdy     = '0;
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      checkOutputs(0, cyc);
      checkOutputs(1, cyc);
      phase   = (cyc / 64) % 4;
      reset   = (cyc < 2) || ($urandom_range(0, 999) < 5);
      flushIn = ($urandom_range(0, 99) < 2);
      for (int j = 0; j < 4; j++) begin
        gValid[j]         = ($urandom_range(0, 99) < 35);
        gIdFlat[j*5 +: 5] = 5'($urandom_range(0, 31));
      end
      case (phase)
        0:       rdy = 4'($urandom);
        1:       rdy = 4'hF;
        2:       for (int p = 0; p < 4; p++) rdy[p] = ($urandom_range(0, 3) == 0);
        default: rdy = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      endcase
      modelStep(0);
      modelStep(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
